// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX between N byte-stream requesters, with an idle gap after each frame.
// Optional packet lock (no interleaving of multi-byte packets) is enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
  parameter int N          = 4,
  parameter int GAP_CYCLES = 8,
  parameter int GW         = 8
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [N-1:0]   req_last,
`endif
  output logic [N-1:0]   req_ack,
  output logic           tx_start,
  output logic [7:0]     tx_data,
  input  logic           tx_ready,
  output logic [2:0]     grant_id,
  output logic           busy
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_DONE, GAP} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] rr_q, rr_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [1:0]    wl_q, wl_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [N-1:0]  req_ack_q, req_ack_d;
  logic [2:0]    grant_q, grant_d;
  logic          busy_q, busy_d;
`ifdef UART_ARB_LOCK_EN
  logic          lock_q, lock_d;
  logic [PW-1:0] lock_id_q, lock_id_d;
`endif

  logic [PW-1:0] base;
  logic [N-1:0]  elig;
  logic          win_ok;
  logic [PW-1:0] win_idx;

  function automatic logic [PW-1:0] inc_mod(input logic [PW-1:0] v);
    logic [PW-1:0] r;
    if (int'(v) >= N - 1) r = '0;
    else r = PW'(int'(v) + 1);
    return r;
  endfunction

  // Winner: first eligible request scanning upward from base, wrapping modulo N.
  always_comb begin
    int idx;
    base    = rr_q;
    elig    = req;
    win_ok  = 1'b0;
    win_idx = '0;
    idx     = 0;
`ifdef UART_ARB_LOCK_EN
    if (lock_q) begin
      if (req[lock_id_q]) begin
        elig            = '0;
        elig[lock_id_q] = 1'b1;
      end else begin
        base = inc_mod(lock_id_q);
      end
    end
`endif
    for (int i = 0; i < N; i++) begin
      idx = int'(base) + i;
      if (idx >= N) idx = idx - N;
      if (!win_ok && elig[idx]) begin
        win_ok  = 1'b1;
        win_idx = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    gap_d      = gap_q;
    wl_d       = wl_q;
    tx_start_d = 1'b0;
    req_ack_d  = '0;
    tx_data_d  = tx_data_q;
    grant_d    = grant_q;
`ifdef UART_ARB_LOCK_EN
    lock_d     = lock_q;
    lock_id_d  = lock_id_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef UART_ARB_LOCK_EN
        if (lock_q && !req[lock_id_q]) begin
          lock_d = 1'b0;
          rr_d   = inc_mod(lock_id_q);
        end
`endif
        if (tx_ready && win_ok) begin
          tx_start_d         = 1'b1;
          req_ack_d[win_idx] = 1'b1;
          tx_data_d          = req_data[8*int'(win_idx) +: 8];
          grant_d            = 3'(win_idx);
          wl_d               = '0;
          state_d            = WAIT_LOW;
`ifdef UART_ARB_LOCK_EN
          if (req_last[win_idx]) begin
            lock_d = 1'b0;
            rr_d   = inc_mod(win_idx);
          end else begin
            lock_d    = 1'b1;
            lock_id_d = win_idx;
          end
`else
          rr_d = inc_mod(win_idx);
`endif
        end
      end
      // Time out after 4 cycles so a transmitter that never drops ready cannot stall us.
      WAIT_LOW: begin
        if (!tx_ready || wl_q == 2'd3) state_d = WAIT_DONE;
        else wl_d = wl_q + 2'd1;
      end
      WAIT_DONE: begin
        if (tx_ready) begin
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            gap_d   = GAP_LOAD;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else gap_d = gap_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      gap_q      <= '0;
      wl_q       <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      req_ack_q  <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      lock_q     <= 1'b0;
      lock_id_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      gap_q      <= gap_d;
      wl_q       <= wl_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      req_ack_q  <= req_ack_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
`ifdef UART_ARB_LOCK_EN
      lock_q     <= lock_d;
      lock_id_q  <= lock_id_d;
`endif
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign req_ack  = req_ack_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a 4-requester instance (gap 8) and a 3-requester instance (gap 0).
module tb_uart_tx_arbiter;
  logic        clk;
  logic        nrst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [2:0]  grant_id;
  logic        busy;
`ifdef UART_ARB_LOCK_EN
  logic [3:0]  req_last;
  logic [2:0]  req_last3;
`endif

  logic [2:0]  req3;
  logic [23:0] data3;
  logic [2:0]  ack3;
  logic        start3;
  logic [7:0]  txd3;
  logic        rdy3;
  logic [2:0]  gid3;
  logic        busy3;

  int vecs;
  int miss;

  typedef struct {
    logic [3:0] req;
    int         wait_n;
    int         id;
    logic [7:0] data;
  } vec_t;
  vec_t tbl[11];

  uart_tx_arbiter #(.N(4), .GAP_CYCLES(8), .GW(8)) dut (
    .clk(clk), .nrst(nrst), .req(req), .req_data(req_data),
`ifdef UART_ARB_LOCK_EN
    .req_last(req_last),
`endif
    .req_ack(req_ack), .tx_start(tx_start), .tx_data(tx_data),
    .tx_ready(tx_ready), .grant_id(grant_id), .busy(busy)
  );

  uart_tx_arbiter #(.N(3), .GAP_CYCLES(0), .GW(4)) dut3 (
    .clk(clk), .nrst(nrst), .req(req3), .req_data(data3),
`ifdef UART_ARB_LOCK_EN
    .req_last(req_last3),
`endif
    .req_ack(ack3), .tx_start(start3), .tx_data(txd3),
    .tx_ready(rdy3), .grant_id(gid3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, what, act, exp);
    end
  endtask

  task automatic wait_start(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_start && n < 60);
    if (!tx_start) n = -1;
  endtask

  task automatic wait3(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!start3 && n < 60);
    if (!start3) n = -1;
  endtask

  // One frame on the 4-way instance; stuck=1 leaves tx_ready high throughout.
  task automatic frame(input string nm, input int exp_wait, input int exp_id,
                       input logic [7:0] exp_data, input bit stuck);
    int n;
    wait_start(n);
    chk(nm, "wait", 32'(n), 32'(exp_wait));
    if (n < 0) return;
    chk(nm, "data", 32'(tx_data), 32'(exp_data));
    chk(nm, "grant", 32'(grant_id), 32'(exp_id));
    chk(nm, "ack", 32'(req_ack), 32'(4'b0001 << exp_id));
    chk(nm, "busy", 32'(busy), 32'd1);
    if (!stuck) tx_ready = 1'b0;
    @(negedge clk);
    chk(nm, "pulse", 32'({tx_start, req_ack}), 32'd0);
    if (!stuck) begin
      repeat (8) @(negedge clk);
      tx_ready = 1'b1;
    end
  endtask

  initial begin
    int n;
    vecs = 0;
    miss = 0;
    tbl[0]  = '{4'b1111, 1,  0, 8'h00};
    tbl[1]  = '{4'b1111, 10, 1, 8'hFF};
    tbl[2]  = '{4'b1111, 10, 2, 8'h1C};
    tbl[3]  = '{4'b1111, 10, 3, 8'h5E};
    tbl[4]  = '{4'b1111, 10, 0, 8'h00};
    tbl[5]  = '{4'b0101, 10, 2, 8'h1C};
    tbl[6]  = '{4'b0101, 10, 0, 8'h00};
    tbl[7]  = '{4'b0101, 10, 2, 8'h1C};
    tbl[8]  = '{4'b1000, 10, 3, 8'h5E};
    tbl[9]  = '{4'b0110, 10, 1, 8'hFF};
    tbl[10] = '{4'b0110, 10, 2, 8'h1C};

    nrst = 1'b0; req = '0; req_data = '0; tx_ready = 1'b1;
    req3 = '0; data3 = '0; rdy3 = 1'b1;
`ifdef UART_ARB_LOCK_EN
    req_last = '0; req_last3 = '0;
`endif
    repeat (2) @(negedge clk);
    chk("reset", "outs", 32'({tx_start, req_ack, tx_data, grant_id, busy}), 32'd0);
    chk("reset", "outs3", 32'({start3, ack3, txd3, gid3, busy3}), 32'd0);
    nrst = 1'b1;

    // N=3, zero gap, stuck ready: pointer wraps from 2 to 0.
    req3 = 3'b100; data3 = {8'hC2, 8'hB1, 8'hA0};
    wait3(n);
    chk("wrap1", "wait", 32'(n), 32'd1);
    chk("wrap1", "gnt", 32'({gid3, ack3, txd3}), 32'({3'd2, 3'b100, 8'hC2}));
    req3 = 3'b101;
    wait3(n);
    chk("wrap2", "wait", 32'(n), 32'd6);
    chk("wrap2", "gnt", 32'({gid3, ack3, txd3}), 32'({3'd0, 3'b001, 8'hA0}));
    wait3(n);
    chk("wrap3", "wait", 32'(n), 32'd6);
    chk("wrap3", "gnt", 32'({gid3, ack3, txd3}), 32'({3'd2, 3'b100, 8'hC2}));
    req3 = '0;

    // Single requester, then its next byte after the gap.
    req = 4'b0001; req_data[7:0] = 8'h5A;
    frame("single", 1, 0, 8'h5A, 1'b0);
    req_data[7:0] = 8'hA5;
    frame("single_gap", 10, 0, 8'hA5, 1'b0);
    req = '0;
    @(negedge clk); nrst = 1'b0;
    @(negedge clk); nrst = 1'b1;

    req_data = 32'h5E1CFF00;
    for (int i = 0; i < 11; i++) begin
      req = tbl[i].req;
      frame($sformatf("rr%0d", i), tbl[i].wait_n, tbl[i].id, tbl[i].data, 1'b0);
    end

    // Transmitter never drops ready: 4-cycle timeout, then full gap.
    req = 4'b0010;
    frame("stuck_a", 10, 1, 8'hFF, 1'b1);
    frame("stuck_b", 13, 1, 8'hFF, 1'b1);
    req = '0;
    repeat (20) @(negedge clk);
    chk("idle", "busy", 32'({busy, tx_start}), 32'd0);
    chk("idle", "held", 32'(tx_data), 32'hFF);

    // Reset during WAIT_DONE; pointer must come back at 0.
    req = 4'b0001; req_data[7:0] = 8'h33;
    wait_start(n);
    chk("rst_pre", "wait", 32'(n), 32'd1);
    chk("rst_pre", "grant", 32'(grant_id), 32'd0);
    tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pre", "busy", 32'(busy), 32'd1);
    #2 nrst = 1'b0;
    #1 chk("rst_mid", "outs", 32'({tx_start, req_ack, tx_data, grant_id, busy}), 32'd0);
    @(negedge clk);
    tx_ready = 1'b1; req = 4'b0011; req_data[15:0] = 16'h5544;
    nrst = 1'b1;
    frame("rst_post", 1, 0, 8'h44, 1'b0);
    frame("rst_post2", 10, 1, 8'h55, 1'b0);
    req = '0;

`ifdef UART_ARB_LOCK_EN
    @(negedge clk); nrst = 1'b0;
    @(negedge clk); nrst = 1'b1;
    req = 4'b0011; req_last = 4'b0000; req_data[15:0] = 16'h2010;
    frame("lock1", 1, 0, 8'h10, 1'b0);
    req_data[7:0] = 8'h11;
    frame("lock2", 10, 0, 8'h11, 1'b0);
    req_data[7:0] = 8'h12; req_last = 4'b0001;
    frame("lock3", 10, 0, 8'h12, 1'b0);
    req_last = 4'b0000;
    frame("lock4", 10, 1, 8'h20, 1'b0);
    req = '0;
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
